// File: rtl/lnrv_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// lnrv_pipe_ctrl
//   Central pipeline sequencer for the IFU/IDU/EXU stage chain. A flush pulse
//   (trap, mispredict) or a debug halt level is turned into per-stage
//   request/ack handshakes. Once every stage has acknowledged a flush (or the
//   flush timer expires), a single PC redirect is issued to the IFU.
//
// Ports
//   clk, reset        clock / asynchronous active-high reset
//   flush_req/pc      1-cycle flush pulse and restart PC
//   flush_busy        flush sequence in progress
//   flush_done        1-cycle pulse, all stages flushed
//   flush_tmo         1-cycle pulse with flush_done when forced by timeout
//   halt_req          debug halt level
//   halt_ack          level, every stage halted
//   stg_flush_req/ack per-stage flush handshake (ack may be pulse or level)
//   stg_halt_req/ack  per-stage halt handshake (level)
//   redirect_vld/pc   1-cycle restart pulse and PC to the IFU
//
//   Every output is a flop whose next value is derived from the next state,
//   so requests appear one cycle after the event that caused them.
// -----------------------------------------------------------------------------
module lnrv_pipe_ctrl #(
   parameter int P_NSTG  = 3,
   parameter int P_TMO_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_req,
   input  logic [31:0]       flush_pc,
   output logic              flush_busy,
   output logic              flush_done,
   output logic              flush_tmo,
   input  logic              halt_req,
   output logic              halt_ack,
   output logic [P_NSTG-1:0] stg_flush_req,
   input  logic [P_NSTG-1:0] stg_flush_ack,
   output logic [P_NSTG-1:0] stg_halt_req,
   input  logic [P_NSTG-1:0] stg_halt_ack,
   output logic              redirect_vld,
   output logic [31:0]       redirect_pc
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FLUSH     = 3'd1,
      S_DONE      = 3'd2,
      S_HALT_WAIT = 3'd3,
      S_HALTED    = 3'd4,
      S_RESUME    = 3'd5
   } state_t;

   localparam logic [P_NSTG-1:0]  ALL_STG = '1;
   localparam logic [P_TMO_W-1:0] TMO_MAX = '1;

   state_t             state_q, state_d;
   logic [P_NSTG-1:0]  mask_q, mask_d;
   logic [P_TMO_W-1:0] timer_q, timer_d;
   logic [31:0]        pc_q, pc_d;
   logic               hold_q, hold_d;     // keep stg_halt_req up across a flush taken from halt
   logic               tmo_d;
   logic [P_NSTG-1:0]  acc;
   logic [P_TMO_W-1:0] timer_inc;

   logic               flush_busy_q, flush_busy_d;
   logic               flush_done_q, flush_done_d;
   logic               flush_tmo_q, flush_tmo_d;
   logic               halt_ack_q, halt_ack_d;
   logic [P_NSTG-1:0]  stg_flush_req_q, stg_flush_req_d;
   logic [P_NSTG-1:0]  stg_halt_req_q, stg_halt_req_d;
   logic               redirect_vld_q, redirect_vld_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      timer_d   = timer_q;
      pc_d      = pc_q;
      hold_d    = hold_q;
      tmo_d     = 1'b0;
      acc       = mask_q;
      timer_inc = (timer_q == TMO_MAX) ? TMO_MAX : timer_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               pc_d    = flush_pc;
               hold_d  = 1'b0;
            end else if (halt_req) begin
               state_d = S_HALT_WAIT;
            end
         end
         S_FLUSH: begin
            if (flush_req) begin
               // Restart: only the most recent PC is ever redirected.
               pc_d    = flush_pc;
               mask_d  = '0;
               timer_d = '0;
            end else begin
               // Timer is zero only in the first cycle of a sequence; an ack
               // seen there still belongs to the previous request and is dropped.
               acc     = (timer_q == '0) ? mask_q : (mask_q | stg_flush_ack);
               mask_d  = acc;
               timer_d = timer_inc;
               if (&acc) begin
                  state_d = S_DONE;
               end else if (&timer_inc) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               pc_d    = flush_pc;
               hold_d  = hold_q & halt_req;
            end else if (halt_req) begin
               state_d = S_HALT_WAIT;
               hold_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
               hold_d  = 1'b0;
            end
         end
         S_HALT_WAIT: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               pc_d    = flush_pc;
               hold_d  = 1'b1;
            end else if (!halt_req) begin
               state_d = S_RESUME;
            end else begin
               acc    = mask_q | stg_halt_ack;
               mask_d = acc;
               if (&acc) state_d = S_HALTED;
            end
         end
         S_HALTED: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               pc_d    = flush_pc;
               hold_d  = 1'b1;
            end else if (!halt_req) begin
               state_d = S_RESUME;
            end
         end
         S_RESUME: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               pc_d    = flush_pc;
               hold_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Fresh mask and timer on every state entry.
      if (state_d != state_q) begin
         mask_d  = '0;
         timer_d = '0;
      end

      flush_busy_d    = (state_d == S_FLUSH);
      flush_done_d    = (state_d == S_DONE);
      flush_tmo_d     = tmo_d;
      halt_ack_d      = (state_d == S_HALTED);
      stg_flush_req_d = (state_d == S_FLUSH) ? ~mask_d : '0;
      stg_halt_req_d  = ((state_d == S_HALT_WAIT) || (state_d == S_HALTED) ||
                         (hold_d && ((state_d == S_FLUSH) || (state_d == S_DONE)))) ? ALL_STG : '0;
      redirect_vld_d  = (state_d == S_DONE);
      redirect_pc_d   = (state_d == S_DONE) ? pc_d : redirect_pc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         mask_q          <= '0;
         timer_q         <= '0;
         pc_q            <= '0;
         hold_q          <= 1'b0;
         flush_busy_q    <= 1'b0;
         flush_done_q    <= 1'b0;
         flush_tmo_q     <= 1'b0;
         halt_ack_q      <= 1'b0;
         stg_flush_req_q <= '0;
         stg_halt_req_q  <= '0;
         redirect_vld_q  <= 1'b0;
         redirect_pc_q   <= '0;
      end else begin
         state_q         <= state_d;
         mask_q          <= mask_d;
         timer_q         <= timer_d;
         pc_q            <= pc_d;
         hold_q          <= hold_d;
         flush_busy_q    <= flush_busy_d;
         flush_done_q    <= flush_done_d;
         flush_tmo_q     <= flush_tmo_d;
         halt_ack_q      <= halt_ack_d;
         stg_flush_req_q <= stg_flush_req_d;
         stg_halt_req_q  <= stg_halt_req_d;
         redirect_vld_q  <= redirect_vld_d;
         redirect_pc_q   <= redirect_pc_d;
      end
   end

   assign flush_busy    = flush_busy_q;
   assign flush_done    = flush_done_q;
   assign flush_tmo     = flush_tmo_q;
   assign halt_ack      = halt_ack_q;
   assign stg_flush_req = stg_flush_req_q;
   assign stg_halt_req  = stg_halt_req_q;
   assign redirect_vld  = redirect_vld_q;
   assign redirect_pc   = redirect_pc_q;

endmodule

// File: tb/tb_lnrv_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lnrv_pipe_ctrl
//   Directed bench for lnrv_pipe_ctrl with a 4-bit flush timer. Inputs are
//   changed 1 ns after a rising edge; outputs are sampled at the same point,
//   so each tick() advances exactly one cycle of the scenario timelines.
// -----------------------------------------------------------------------------
module tb_lnrv_pipe_ctrl;

   logic        clk;
   logic        reset;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic        flush_busy;
   logic        flush_done;
   logic        flush_tmo;
   logic        halt_req;
   logic        halt_ack;
   logic [2:0]  stg_flush_req;
   logic [2:0]  stg_flush_ack;
   logic [2:0]  stg_halt_req;
   logic [2:0]  stg_halt_ack;
   logic        redirect_vld;
   logic [31:0] redirect_pc;

   int vectors = 0;
   int errs    = 0;

   lnrv_pipe_ctrl #(.P_NSTG(3), .P_TMO_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush_req    (flush_req),
      .flush_pc     (flush_pc),
      .flush_busy   (flush_busy),
      .flush_done   (flush_done),
      .flush_tmo    (flush_tmo),
      .halt_req     (halt_req),
      .halt_ack     (halt_ack),
      .stg_flush_req(stg_flush_req),
      .stg_flush_ack(stg_flush_ack),
      .stg_halt_req (stg_halt_req),
      .stg_halt_ack (stg_halt_ack),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic busy, input logic done,
                          input logic tmo, input logic hack, input logic [2:0] sfr,
                          input logic [2:0] shr, input logic rv);
      chk({tag, ".busy"}, {31'd0, flush_busy}, {31'd0, busy});
      chk({tag, ".done"}, {31'd0, flush_done}, {31'd0, done});
      chk({tag, ".tmo"},  {31'd0, flush_tmo},  {31'd0, tmo});
      chk({tag, ".hack"}, {31'd0, halt_ack},   {31'd0, hack});
      chk({tag, ".sfr"},  {29'd0, stg_flush_req}, {29'd0, sfr});
      chk({tag, ".shr"},  {29'd0, stg_halt_req},  {29'd0, shr});
      chk({tag, ".rv"},   {31'd0, redirect_vld},  {31'd0, rv});
   endtask

   initial begin
      reset         = 1'b1;
      flush_req     = 1'b0;
      flush_pc      = 32'h0;
      halt_req      = 1'b0;
      stg_flush_ack = 3'b000;
      stg_halt_ack  = 3'b000;

      // ---------------- reset state
      tick(); tick();
      chk_all("rst", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      chk("rst.rpc", redirect_pc, 32'h0);
      reset = 1'b0;
      tick();
      chk_all("idle", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      // ---------------- T1: staggered acks
      flush_pc = 32'h8000_0040; flush_req = 1'b1;           // c0
      tick(); flush_req = 1'b0;                              // c1
      chk_all("t1.c1", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      tick();                                                // c2
      chk_all("t1.c2", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      stg_flush_ack = 3'b001;
      tick();                                                // c3
      chk_all("t1.c3", 1, 0, 0, 0, 3'b110, 3'b000, 0);
      stg_flush_ack = 3'b110;
      tick(); stg_flush_ack = 3'b000;                        // c4
      chk_all("t1.c4", 0, 1, 0, 0, 3'b000, 3'b000, 1);
      chk("t1.rpc", redirect_pc, 32'h8000_0040);
      tick();                                                // c5
      chk_all("t1.c5", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      // ---------------- T2: restart, stale ack ignored
      flush_pc = 32'h100; flush_req = 1'b1;                  // c0
      tick(); flush_req = 1'b0;                              // c1
      tick();                                                // c2
      flush_pc = 32'h200; flush_req = 1'b1;
      tick(); flush_req = 1'b0;                              // c3
      chk_all("t2.c3", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      stg_flush_ack = 3'b111;
      tick(); stg_flush_ack = 3'b000;                        // c4
      chk_all("t2.c4", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      tick();                                                // c5
      stg_flush_ack = 3'b111;
      tick(); stg_flush_ack = 3'b000;                        // c6
      chk_all("t2.c6", 0, 1, 0, 0, 3'b000, 3'b000, 1);
      chk("t2.rpc", redirect_pc, 32'h200);
      tick();                                                // c7
      chk_all("t2.c7", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      // ---------------- T3: halt and resume
      halt_req = 1'b1;                                       // c0
      tick();                                                // c1
      chk_all("t3.c1", 0, 0, 0, 0, 3'b000, 3'b111, 0);
      tick();                                                // c2
      tick();                                                // c3
      chk_all("t3.c3", 0, 0, 0, 0, 3'b000, 3'b111, 0);
      stg_halt_ack = 3'b111;
      tick();                                                // c4
      chk_all("t3.c4", 0, 0, 0, 1, 3'b000, 3'b111, 0);
      tick();                                                // c5
      tick();                                                // c6
      chk_all("t3.c6", 0, 0, 0, 1, 3'b000, 3'b111, 0);
      halt_req = 1'b0;
      tick();                                                // c7 RESUME
      chk_all("t3.c7", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      stg_halt_ack = 3'b000;
      tick();                                                // c8 IDLE
      chk_all("t3.c8", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      // ---------------- T4: flush while halted
      halt_req = 1'b1; stg_halt_ack = 3'b111;                // c0
      tick();                                                // c1 HALT_WAIT
      tick();                                                // c2 HALTED
      chk_all("t4.c2", 0, 0, 0, 1, 3'b000, 3'b111, 0);
      flush_pc = 32'h300; flush_req = 1'b1;
      tick(); flush_req = 1'b0;                              // c3 FLUSH
      chk_all("t4.c3", 1, 0, 0, 0, 3'b111, 3'b111, 0);
      tick();                                                // c4
      stg_flush_ack = 3'b111;
      tick(); stg_flush_ack = 3'b000;                        // c5 DONE
      chk_all("t4.c5", 0, 1, 0, 0, 3'b000, 3'b111, 1);
      chk("t4.rpc", redirect_pc, 32'h300);
      tick();                                                // c6 HALT_WAIT
      chk_all("t4.c6", 0, 0, 0, 0, 3'b000, 3'b111, 0);
      tick();                                                // c7 HALTED
      chk_all("t4.c7", 0, 0, 0, 1, 3'b000, 3'b111, 0);
      halt_req = 1'b0;
      tick(); stg_halt_ack = 3'b000;                         // c8 RESUME
      chk_all("t4.c8", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      tick();                                                // c9 IDLE

      // ---------------- T5: IDU never acks -> timeout after 15 FLUSH cycles
      flush_pc = 32'h400; flush_req = 1'b1; stg_flush_ack = 3'b101;   // c0
      tick(); flush_req = 1'b0;                              // c1
      chk_all("t5.c1", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      repeat (14) tick();                                    // c15
      chk_all("t5.c15", 1, 0, 0, 0, 3'b010, 3'b000, 0);
      tick();                                                // c16
      chk_all("t5.c16", 0, 1, 1, 0, 3'b000, 3'b000, 1);
      chk("t5.rpc", redirect_pc, 32'h400);
      stg_flush_ack = 3'b000;
      tick();                                                // c17
      chk_all("t5.c17", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      // ---------------- T6: asynchronous reset during FLUSH
      flush_pc = 32'h500; flush_req = 1'b1;                  // c0
      tick(); flush_req = 1'b0;                              // c1
      chk_all("t6.c1", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      #2 reset = 1'b1;
      #1;
      chk_all("t6.async", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      chk("t6.rpc", redirect_pc, 32'h0);
      stg_flush_ack = 3'b111;
      tick(); reset = 1'b0;
      tick();
      chk_all("t6.post1", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      tick();
      chk_all("t6.post2", 0, 0, 0, 0, 3'b000, 3'b000, 0);
      stg_flush_ack = 3'b000;

      // ---------------- T7: flush has priority over halt in IDLE
      flush_pc = 32'h600; flush_req = 1'b1; halt_req = 1'b1; // c0
      tick(); flush_req = 1'b0;                              // c1
      chk_all("t7.c1", 1, 0, 0, 0, 3'b111, 3'b000, 0);
      tick();                                                // c2
      stg_flush_ack = 3'b111;
      tick(); stg_flush_ack = 3'b000;                        // c3 DONE
      chk_all("t7.c3", 0, 1, 0, 0, 3'b000, 3'b000, 1);
      chk("t7.rpc", redirect_pc, 32'h600);
      tick();                                                // c4 HALT_WAIT
      chk_all("t7.c4", 0, 0, 0, 0, 3'b000, 3'b111, 0);
      halt_req = 1'b0;
      tick();                                                // c5 RESUME
      tick();                                                // c6 IDLE
      chk_all("t7.c6", 0, 0, 0, 0, 3'b000, 3'b000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
